// File: rtl/timer_wb.sv
// timer_wb: BK0010 programmable interval timer (RELOAD/COUNT/CSR) on the wishbone CPU bus
module timer_wb #(
    parameter int PRESCALE = 128
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        expired_o
);
    localparam int PW = $clog2(PRESCALE) + 6;
    localparam logic [15:0] A_RELOAD = 16'o177706;
    localparam logic [15:0] A_COUNT  = 16'o177710;
    localparam logic [15:0] A_CSR    = 16'o177712;

    logic [15:0]   reload_q, reload_d, count_q, count_d, wmask, rd_mux;
    logic [7:0]    csr_q, csr_d;
    logic [PW-1:0] psc_q, psc_d, psc_lim;
    logic          ack_q, sel_reload, sel_count, sel_csr, hit, wr;
    logic          csr_wr, csr_lo, run_set, counting, tick, expire;
    logic [1:0]    lanes;

    assign sel_reload = (wb_adr_i | 16'd1) == (A_RELOAD | 16'd1);
    assign sel_count  = (wb_adr_i | 16'd1) == (A_COUNT | 16'd1);
    assign sel_csr    = (wb_adr_i | 16'd1) == (A_CSR | 16'd1);
    assign hit        = wb_cyc_i & wb_stb_i & (sel_reload | sel_count | sel_csr);
    assign wr         = hit & wb_we_i & ~ack_q;
    assign lanes      = wb_sel_i == 2'b00 ? 2'b11 : wb_sel_i;
    assign wmask      = {{8{lanes[1]}}, {8{lanes[0]}}};
    assign csr_wr     = wr & sel_csr;
    assign csr_lo     = csr_wr & lanes[0];
    assign run_set    = csr_lo & wb_dat_i[4];

    assign rd_mux   = sel_reload ? reload_q : sel_count ? count_q : {8'hFF, csr_q};
    assign wb_dat_o = hit & ~wb_we_i ? rd_mux : 16'd0;
    assign wb_ack_o = ack_q;
    assign expired_o = csr_q[7];

    // divisor select: DIV16|DIV4 together give x64
    assign psc_lim  = csr_q[6] & csr_q[5] ? PW'(PRESCALE * 64 - 1) :
                      csr_q[6] ? PW'(PRESCALE * 4 - 1) :
                      csr_q[5] ? PW'(PRESCALE * 16 - 1) : PW'(PRESCALE - 1);
    assign counting = csr_q[4] & ~csr_q[0];
    assign tick     = counting & (psc_q == psc_lim);
    assign expire   = tick & ~|count_q;

    // a CSR write swallows the tick, but an expiry still sets EXPIRED over a clearing write
    always_comb begin
        reload_d   = wr & sel_reload ? (reload_q & ~wmask) | (wb_dat_i & wmask) : reload_q;
        psc_d      = csr_wr | tick ? '0 : counting ? psc_q + 1'b1 : psc_q;
        csr_d[7]   = (csr_lo ? csr_q[7] & wb_dat_i[7] : csr_q[7]) | (expire & csr_q[2]);
        csr_d[6:0] = csr_lo ? wb_dat_i[6:0] :
                     {csr_q[6:5], csr_q[4] & ~(expire & ~csr_wr & csr_q[3]), csr_q[3:0]};
        count_d    = run_set ? reload_q :
                     csr_wr | ~tick ? count_q :
                     |count_q ? count_q - 1'b1 :
                     csr_q[1] ? 16'hFFFF : reload_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            reload_q <= 16'd0;
            count_q  <= 16'hFFFF;
            csr_q    <= 8'd0;
            psc_q    <= '0;
            ack_q    <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            csr_q    <= csr_d;
            psc_q    <= psc_d;
            ack_q    <= hit & ~ack_q;
        end
    end
endmodule

// File: tb/tb_timer_wb.sv
// tb_timer_wb: directed bench for timer_wb with PRESCALE=4
module tb_timer_wb;
    localparam logic [15:0] A_RELOAD = 16'o177706;
    localparam logic [15:0] A_COUNT  = 16'o177710;
    localparam logic [15:0] A_CSR    = 16'o177712;
    localparam logic [15:0] A_NONE   = 16'o177714;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] adr = '0, dat_i = '0, dat_o;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, expired;
    logic [1:0]  sel = 2'b11;
    logic [15:0] d, d2;
    int          n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    timer_wb #(.PRESCALE(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel), .wb_ack_o(ack),
        .expired_o(expired)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // d: data on the strobe cycle, d2: data on the ack cycle
    task automatic rd(input logic [15:0] a, output logic [15:0] dv, output logic [15:0] dv2);
        @(negedge clk);
        adr = a; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
        #1 dv = dat_o;
        chk("rd_ack_early", {15'd0, ack}, 16'd0);
        @(negedge clk);
        dv2 = dat_o;
        chk("rd_ack", {15'd0, ack}, 16'd1);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v, input logic [1:0] s);
        @(negedge clk);
        adr = a; dat_i = v; we = 1'b1; sel = s; cyc = 1'b1; stb = 1'b1;
        #1 chk("wr_ack_early", {15'd0, ack}, 16'd0);
        @(negedge clk);
        chk("wr_ack", {15'd0, ack}, 16'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 2'b11;
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        rd(A_CSR, d, d2);
        chk("rst_csr", d, 16'hFF00);
        @(negedge clk);
        chk("ack_one_cycle", {15'd0, ack}, 16'd0);
        rd(A_COUNT, d, d2);
        chk("rst_count", d, 16'hFFFF);
        chk("rst_expired", {15'd0, expired}, 16'd0);

        wr(A_RELOAD, 16'd3, 2'b11);
        rd(A_RELOAD, d, d2);
        chk("reload_rb", d, 16'd3);
        wr(A_CSR, 16'h0014, 2'b11);
        rd(A_COUNT, d, d2);
        chk("cnt3", d, 16'd3);
        idle(2); rd(A_COUNT, d, d2);
        chk("cnt2", d, 16'd2);
        idle(2); rd(A_COUNT, d, d2);
        chk("cnt1", d, 16'd1);
        idle(2); rd(A_COUNT, d, d2);
        chk("cnt0", d, 16'd0);
        chk("exp_before", {15'd0, expired}, 16'd0);
        idle(2); rd(A_COUNT, d, d2);
        chk("cnt_reload", d, 16'd3);
        chk("exp_after", {15'd0, expired}, 16'd1);
        rd(A_CSR, d, d2);
        chk("csr_expired", d, 16'hFF94);

        wr(A_CSR, 16'h001E, 2'b11);
        rd(A_COUNT, d, d2);
        chk("os_cnt3", d, 16'd3);
        idle(2); rd(A_COUNT, d, d2);
        idle(2); rd(A_COUNT, d, d2);
        idle(2); rd(A_COUNT, d, d2);
        chk("os_cnt0", d, 16'd0);
        idle(2); rd(A_COUNT, d, d2);
        chk("os_wrap", d, 16'hFFFF);
        rd(A_CSR, d, d2);
        chk("os_csr", d, 16'hFF8E);
        idle(100); rd(A_COUNT, d, d2);
        chk("os_hold", d, 16'hFFFF);

        wr(A_RELOAD, 16'd10, 2'b11);
        wr(A_CSR, 16'h0070, 2'b11);
        idle(254); rd(A_COUNT, d, d2);
        chk("div64_pre", d, 16'd10);
        chk("div64_tick", d2, 16'd9);
        wr(A_CSR, 16'h0071, 2'b11);
        idle(300); rd(A_COUNT, d, d2);
        chk("stop_frozen", d, 16'd10);
        wr(A_CSR, 16'h0070, 2'b11);
        idle(254); rd(A_COUNT, d, d2);
        chk("resume_pre", d, 16'd10);
        chk("resume_tick", d2, 16'd9);

        wr(A_RELOAD, 16'hABCD, 2'b01);
        rd(A_RELOAD, d, d2);
        chk("reload_lane", d, 16'h00CD);
        wr(A_CSR, 16'h00FF, 2'b10);
        rd(A_CSR, d, d2);
        chk("csr_hi_lane", d, 16'hFF70);
        wr(A_CSR, 16'h0080, 2'b11);
        rd(A_CSR, d, d2);
        chk("exp_w1_ignored", d, 16'hFF00);
        chk("exp_w1_pin", {15'd0, expired}, 16'd0);

        wr(A_RELOAD, 16'h0000, 2'b00);
        rd(A_RELOAD, d, d2);
        chk("sel00_write", d, 16'h0000);
        wr(A_CSR, 16'h0014, 2'b11);
        idle(6);
        wr(A_CSR, 16'h0014, 2'b11);
        rd(A_CSR, d, d2);
        chk("exp_set_wins", d, 16'hFF94);
        chk("exp_set_pin", {15'd0, expired}, 16'd1);
        idle(1);
        wr(A_CSR, 16'h0004, 2'b11);
        rd(A_CSR, d, d2);
        chk("exp_cleared", d, 16'hFF04);
        chk("exp_clr_pin", {15'd0, expired}, 16'd0);

        wr(A_COUNT, 16'h1234, 2'b11);
        rd(A_COUNT, d, d2);
        chk("count_ro", d, 16'd0);

        @(negedge clk);
        adr = A_NONE; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        #1 chk("nohit_data", dat_o, 16'd0);
        @(negedge clk);
        chk("nohit_ack", {15'd0, ack}, 16'd0);
        cyc = 1'b0; stb = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
